// File: rtl/acc_cvt_arbiter.sv
// Round-robin arbiter that funnels NREQ MAC result lanes through one shared
// combinational FP32->FP16 converter into a single registered output stage.
module acc_cvt_arbiter #(
    parameter int PARM_XLEN = 32,
    parameter int NREQ      = 4,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_mode,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*PARM_XLEN-1:0] req_data,
    output logic [PARM_XLEN-1:0]      cvt_data_o,
    output logic                      cvt_mode_o,
    input  logic [PARM_XLEN-1:0]      cvt_result_i,
    input  logic                      cvt_of_i,
    input  logic                      cvt_uf_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PARM_XLEN-1:0]      out_data,
    output logic [IDW-1:0]            out_id,
    output logic                      out_of,
    output logic                      out_uf,
    input  logic                      flag_clr,
    output logic                      sticky_of,
    output logic                      sticky_uf,
    output logic [15:0]               cvt_cnt
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                 state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PARM_XLEN-1:0]   out_data_q, out_data_d;
    logic [IDW-1:0]         out_id_q, out_id_d;
    logic                   out_of_q, out_of_d;
    logic                   out_uf_q, out_uf_d;
    logic                   sticky_of_q, sticky_of_d;
    logic                   sticky_uf_q, sticky_uf_d;
    logic [15:0]            cvt_cnt_q, cvt_cnt_d;

    logic                   can_accept;
    logic                   grant_found;
    logic [IDW-1:0]         grant_idx;
    logic                   grant;

    // Search upward from rr_ptr; the index wraps naturally because NREQ is a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            logic [IDW-1:0] idx;
            idx = rr_ptr_q + IDW'(k);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Granting is suppressed while reset is held so no lane sees a handshake.
    always_comb begin
        can_accept = (state_q == EMPTY) | (out_ready & out_valid);
        grant      = rst_n & can_accept & grant_found;
        req_ready  = '0;
        cvt_data_o = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
            cvt_data_o           = req_data[grant_idx*PARM_XLEN +: PARM_XLEN];
        end
        cvt_mode_o = cfg_mode;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (grant) state_d = FULL;
            FULL:    if (grant) state_d = FULL;
                     else if (out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = out_data_q;
        out_id    = out_id_q;
        out_of    = out_of_q;
        out_uf    = out_uf_q;
        sticky_of = sticky_of_q;
        sticky_uf = sticky_uf_q;
        cvt_cnt   = cvt_cnt_q;
    end

    // Flags are only meaningful when the converter actually narrowed the word.
    always_comb begin
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_of_d    = out_of_q;
        out_uf_d    = out_uf_q;
        rr_ptr_d    = rr_ptr_q;
        cvt_cnt_d   = cvt_cnt_q;
        sticky_of_d = sticky_of_q & ~flag_clr;
        sticky_uf_d = sticky_uf_q & ~flag_clr;
        if (grant) begin
            out_data_d = cvt_result_i;
            out_id_d   = grant_idx;
            out_of_d   = cvt_of_i & cfg_mode;
            out_uf_d   = cvt_uf_i & cfg_mode;
            rr_ptr_d   = grant_idx + IDW'(1);
            cvt_cnt_d  = cvt_cnt_q + 16'd1;
            if (cvt_of_i & cfg_mode) sticky_of_d = 1'b1;
            if (cvt_uf_i & cfg_mode) sticky_uf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_of_q    <= 1'b0;
            out_uf_q    <= 1'b0;
            rr_ptr_q    <= '0;
            sticky_of_q <= 1'b0;
            sticky_uf_q <= 1'b0;
            cvt_cnt_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_of_q    <= out_of_d;
            out_uf_q    <= out_uf_d;
            rr_ptr_q    <= rr_ptr_d;
            sticky_of_q <= sticky_of_d;
            sticky_uf_q <= sticky_uf_d;
            cvt_cnt_q   <= cvt_cnt_d;
        end
    end

endmodule

// File: tb/tb_acc_cvt_arbiter.sv
// Scoreboard bench for acc_cvt_arbiter: directed lane patterns push expected words,
// an independent monitor pops and compares them on every output handshake.
module tb_acc_cvt_arbiter;

    localparam int XLEN = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_mode;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_data;
    logic [XLEN-1:0]      cvt_data_o;
    logic                 cvt_mode_o;
    logic [XLEN-1:0]      cvt_result_i;
    logic                 cvt_of_i;
    logic                 cvt_uf_i;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_data;
    logic [IDW-1:0]       out_id;
    logic                 out_of;
    logic                 out_uf;
    logic                 flag_clr;
    logic                 sticky_of;
    logic                 sticky_uf;
    logic [15:0]          cvt_cnt;

    logic [XLEN-1:0]      lane_d [NREQ];

    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
        logic        of;
        logic        uf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    acc_cvt_arbiter #(.PARM_XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_mode     (cfg_mode),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .cvt_data_o   (cvt_data_o),
        .cvt_mode_o   (cvt_mode_o),
        .cvt_result_i (cvt_result_i),
        .cvt_of_i     (cvt_of_i),
        .cvt_uf_i     (cvt_uf_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_id       (out_id),
        .out_of       (out_of),
        .out_uf       (out_uf),
        .flag_clr     (flag_clr),
        .sticky_of    (sticky_of),
        .sticky_uf    (sticky_uf),
        .cvt_cnt      (cvt_cnt)
    );

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*XLEN +: XLEN] = lane_d[i];
    end

    // External converter: flags reflect the FP32 value regardless of mode.
    always_comb begin
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        int          ue;
        logic [15:0] h;
        s  = cvt_data_o[31];
        e  = cvt_data_o[30:23];
        f  = cvt_data_o[22:0];
        ue = int'(e) - 112;
        cvt_of_i = 1'b0;
        cvt_uf_i = 1'b0;
        h = '0;
        if (e == 8'hFF || ue >= 31) begin
            cvt_of_i = 1'b1;
            h = {s, 5'h1F, 10'h000};
        end else if (e == 8'h00) begin
            h = {s, 15'h0000};
        end else if (ue <= 0) begin
            cvt_uf_i = 1'b1;
            h = {s, 15'h0000};
        end else begin
            h = {s, ue[4:0], f[22:13]};
        end
        cvt_result_i = cvt_mode_o ? {16'h0000, h} : cvt_data_o;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [1:0] id, input logic of, input logic uf);
        exp_t e;
        e.data = d;
        e.id   = id;
        e.of   = of;
        e.uf   = uf;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [3:0] vld, input logic mode, input logic ordy, input logic clr);
        req_valid = vld;
        cfg_mode  = mode;
        out_ready = ordy;
        flag_clr  = clr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // A word leaves the DUT at the next edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_word: got data 0x%08h id %0d, expected none", out_data, out_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("sb_data", out_data, e.data);
                check_output("sb_id", 32'(out_id), 32'(e.id));
                check_output("sb_of", 32'(out_of), 32'(e.of));
                check_output("sb_uf", 32'(out_uf), 32'(e.uf));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a_data [NREQ];
        a_data = '{32'h0000_0001, 32'h3F80_0000, 32'h00AB_CDEF, 32'h4780_0000};
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) lane_d[i] = '0;
        apply_stimulus(4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        apply_stimulus(4'hF, 1'b0, 1'b1, 1'b0);
        #1;
        check_output("rst_req_ready", 32'(req_ready), 32'h0);
        check_output("rst_out_valid", 32'(out_valid), 32'h0);
        check_output("rst_out_data", out_data, 32'h0);
        check_output("rst_out_id", 32'(out_id), 32'h0);
        check_output("rst_sticky", 32'({sticky_of, sticky_uf}), 32'h0);
        check_output("rst_cvt_cnt", 32'(cvt_cnt), 32'h0);
        apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // All four lanes busy, pass-through: strict rotation starting at lane 0.
        lane_d = a_data;
        apply_stimulus(4'hF, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            push_exp(a_data[k % NREQ], 2'(k % NREQ), 1'b0, 1'b0);
            #1;
            check_output("rr_req_ready", 32'(req_ready), 32'(1 << (k % NREQ)));
            next_cycle();
        end
        check_output("rr_cvt_cnt", 32'(cvt_cnt), 32'd8);
        apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        check_output("drain_empty", 32'(out_valid), 32'h0);

        // 1.0 converted to half precision on lane 2.
        lane_d[2] = 32'h3F80_0000;
        apply_stimulus(4'b0100, 1'b1, 1'b1, 1'b0);
        push_exp(32'h0000_3C00, 2'd2, 1'b0, 1'b0);
        #1;
        check_output("cvt_req_ready", 32'(req_ready), 32'h4);
        check_output("cvt_data_o", cvt_data_o, 32'h3F80_0000);
        check_output("cvt_mode_o", 32'(cvt_mode_o), 32'h1);
        next_cycle();
        check_output("cvt_out_valid", 32'(out_valid), 32'h1);
        check_output("cvt_out_data", out_data, 32'h0000_3C00);
        check_output("cvt_out_id", 32'(out_id), 32'h2);
        apply_stimulus(4'h0, 1'b1, 1'b1, 1'b0);
        next_cycle();

        // Overflow, sticky clear, and set winning over a concurrent clear.
        lane_d[0] = 32'h4780_0000;
        apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b0);
        push_exp(32'h0000_7C00, 2'd0, 1'b1, 1'b0);
        next_cycle();
        check_output("of_out_of", 32'(out_of), 32'h1);
        check_output("of_sticky_set", 32'(sticky_of), 32'h1);
        apply_stimulus(4'h0, 1'b1, 1'b1, 1'b1);
        next_cycle();
        check_output("of_sticky_clr", 32'(sticky_of), 32'h0);
        apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b1);
        push_exp(32'h0000_7C00, 2'd0, 1'b1, 1'b0);
        next_cycle();
        check_output("of_set_wins", 32'(sticky_of), 32'h1);
        lane_d[1] = 32'h3300_0000;
        apply_stimulus(4'b0010, 1'b1, 1'b1, 1'b0);
        push_exp(32'h0000_0000, 2'd1, 1'b0, 1'b1);
        next_cycle();
        check_output("uf_sticky_set", 32'(sticky_uf), 32'h1);
        check_output("uf_of_kept", 32'(sticky_of), 32'h1);
        apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();

        // Backpressure: output must hold and no lane may be granted.
        lane_d[0] = 32'h1111_1111;
        lane_d[1] = 32'h2222_2222;
        apply_stimulus(4'b0011, 1'b0, 1'b0, 1'b0);
        push_exp(32'h1111_1111, 2'd0, 1'b0, 1'b0);
        #1;
        check_output("bp_first_grant", 32'(req_ready), 32'h1);
        next_cycle();
        apply_stimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            #1;
            check_output("bp_req_ready", 32'(req_ready), 32'h0);
            check_output("bp_hold_data", out_data, 32'h1111_1111);
            check_output("bp_hold_id", 32'(out_id), 32'h0);
            next_cycle();
        end
        apply_stimulus(4'b0010, 1'b0, 1'b1, 1'b0);
        push_exp(32'h2222_2222, 2'd1, 1'b0, 1'b0);
        #1;
        check_output("bp_drain_accept", 32'(req_ready), 32'h2);
        next_cycle();
        check_output("bp_new_data", out_data, 32'h2222_2222);
        check_output("bp_still_full", 32'(out_valid), 32'h1);
        apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();

        // Reset while FULL drops the held word; arbitration restarts at lane 0.
        lane_d[2] = 32'hCAFE_F00D;
        apply_stimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        push_exp(32'hCAFE_F00D, 2'd2, 1'b0, 1'b0);
        next_cycle();
        check_output("pre_rst_full", 32'(out_valid), 32'h1);
        apply_stimulus(4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_valid", 32'(out_valid), 32'h0);
        check_output("async_rst_data", out_data, 32'h0);
        exp_q.delete();
        next_cycle();
        rst_n = 1'b1;
        check_output("post_rst_cnt", 32'(cvt_cnt), 32'h0);
        lane_d[1] = 32'h0000_1111;
        lane_d[3] = 32'h0000_3333;
        apply_stimulus(4'b1010, 1'b0, 1'b1, 1'b0);
        push_exp(32'h0000_1111, 2'd1, 1'b0, 1'b0);
        #1;
        check_output("post_rst_grant1", 32'(req_ready), 32'h2);
        next_cycle();
        apply_stimulus(4'b1000, 1'b0, 1'b1, 1'b0);
        push_exp(32'h0000_3333, 2'd3, 1'b0, 1'b0);
        #1;
        check_output("post_rst_grant3", 32'(req_ready), 32'h8);
        next_cycle();
        apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();

        // Run the counter up to 0xFFFF (two accepts already counted), then wrap.
        apply_stimulus(4'b0001, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65533; i++) begin
            lane_d[0] = 32'(i);
            push_exp(32'(i), 2'd0, 1'b0, 1'b0);
            next_cycle();
        end
        check_output("cnt_at_max", 32'(cvt_cnt), 32'h0000_FFFF);
        lane_d[0] = 32'hDEAD_0000;
        push_exp(32'hDEAD_0000, 2'd0, 1'b0, 1'b0);
        next_cycle();
        check_output("cnt_wrap", 32'(cvt_cnt), 32'h0);
        apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();
        check_output("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_cvt_arbiter.md
ACC_CVT_ARBITER -- requirements
Module: acc_cvt_arbiter

Interface
REQ-001 SHALL have parameter PARM_XLEN, default 32, data word width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesting MAC lanes (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_mode  input  1  1 = FP32->FP16 convert, 0 = pass-through; sampled per accepted word.
REQ-006 SHALL have port req_valid  input  NREQ  per-lane result valid.
REQ-007 SHALL have port req_ready  output  NREQ  per-lane accept, combinational, one-hot or zero.
REQ-008 SHALL have port req_data  input  NREQ*PARM_XLEN  packed FP32 results; lane i at bits [i*32+31:i*32].
REQ-009 SHALL have port cvt_data_o  output  PARM_XLEN  operand to the shared combinational converter.
REQ-010 SHALL have port cvt_mode_o  output  1  mode to the converter.
REQ-011 SHALL have port cvt_result_i  input  PARM_XLEN  converter result, same cycle.
REQ-012 SHALL have ports cvt_of_i, cvt_uf_i  input  1 each  converter overflow/underflow flags.
REQ-013 SHALL have ports out_valid output 1, out_ready input 1, out_data output PARM_XLEN, out_id output log2(NREQ), out_of output 1, out_uf output 1.
REQ-014 SHALL have ports flag_clr input 1 (clear sticky flags), sticky_of output 1, sticky_uf output 1, cvt_cnt output 16.

Function
REQ-015 SHALL implement a 2-state output FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-016 SHALL compute can_accept = (state==EMPTY) | (out_ready & out_valid).
REQ-017 SHALL, when can_accept, grant the first lane with req_valid=1 searching from rr_ptr upward with wrap to 0; req_ready = one-hot of that lane, else all zero.
REQ-018 SHALL drive cvt_data_o = granted lane data and cvt_mode_o = cfg_mode; cvt_data_o = 0 when no grant.
REQ-019 SHALL, on accept, register out_data <= cvt_result_i, out_id <= lane, out_of <= cvt_of_i & cfg_mode, out_uf <= cvt_uf_i & cfg_mode, enter FULL.
REQ-020 SHALL give latency exactly 1 cycle accept -> out_valid; throughput 1 word/cycle while out_ready=1.
REQ-021 SHALL update rr_ptr <= (granted lane + 1) mod NREQ on accept only; unchanged otherwise.
REQ-022 SHALL hold out_* stable while out_valid=1 and out_ready=0 (no accept, req_ready=0).
REQ-023 SHALL go FULL->EMPTY when out_ready=1 and no lane valid; FULL->FULL with new data on simultaneous drain and accept.
REQ-024 SHALL set sticky_of/sticky_uf on accept when the registered flag would be 1; flag_clr clears both; set in same cycle as flag_clr wins.
REQ-025 SHALL increment cvt_cnt on each accept, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL in pass-through mode return cvt_result_i unmodified (converter passes input through).
REQ-027 SHALL never accept more than one lane per cycle nor drop/duplicate words.

Reset
REQ-028 SHALL on rst_n=0 asynchronously clear: state=EMPTY, out_valid=0, out_data=0, out_id=0, out_of=0, out_uf=0, rr_ptr=0, sticky_of=0, sticky_uf=0, cvt_cnt=0.
REQ-029 SHALL drop any word held in the output register when reset asserts mid-operation; req_ready=0 during reset.
REQ-030 SHALL resume granting from lane 0 on first cycle after rst_n deasserts.

Verification
REQ-031 All 4 lanes valid continuously, out_ready=1 -> out_id sequence 0,1,2,3,0,..., one word/cycle, cvt_cnt=8 after 8 cycles.
REQ-032 Lane 2 data 0x3F800000, cfg_mode=1 -> next cycle out_data=0x00003C00, out_id=2, out_of=0.
REQ-033 Lane 0 data 0x47800000 (65536.0), mode=1 -> out_of=1, sticky_of=1; flag_clr pulse -> sticky_of=0; flag_clr concurrent with new OF -> sticky_of=1.
REQ-034 out_ready=0 for 3 cycles with lanes valid -> req_ready=0, out_data/out_id constant; out_ready=1 -> drain and accept same cycle.
REQ-035 Reset asserted while FULL -> out_valid=0 immediately (async); after release lane 3 then lane 1 valid -> grant order 1 then 3 from rr_ptr=0.
REQ-036 cvt_cnt preloaded via 65535 accepts -> next accept gives cvt_cnt=0.
